// File: rtl/multi_counter.sv
// Prescaled up/down counter over DIGITS 4-bit digits: per-digit decimal (BCD=1) or plain binary (BCD=0).
// Synchronous clear/load take priority over tick-gated count steps; Rc flags a wrapping step.
module multi_counter #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned BCD    = 1,
  parameter int unsigned DIV    = 50_000_000
) (
  input  logic                  clk,
  input  logic                  RST_n,
  input  logic                  en,
  input  logic                  up,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   Q,
  output logic                  tick,
  output logic                  Rc
);

  localparam int unsigned W        = 4 * DIGITS;
  localparam int unsigned WC       = W + 1;
  localparam int unsigned PW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_d;
  logic          pre_last_c;

  logic [W-1:0]  up_val_c;
  logic [W-1:0]  dn_val_c;
  logic [W-1:0]  sat_val_c;
  logic          up_wrap_c;
  logic          dn_wrap_c;

  logic [W-1:0]  q_d;
  logic          rc_d;
  logic          step_c;

  // Free-running prescaler; tick is registered so it lands one cycle after pre_q reaches the end.
  always_comb begin
    pre_last_c = (pre_q == PRE_LAST);
    pre_d      = pre_last_c ? '0 : pre_q + PW'(1);
  end

  generate
    if (BCD != 0) begin : g_bcd
      logic [DIGITS:0] carry;
      logic [DIGITS:0] borrow;

      assign carry[0]  = 1'b1;
      assign borrow[0] = 1'b1;

      // Ripple carry/borrow through the decimal digits; loaded digits above 9 saturate.
      for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        logic [3:0] d;
        logic [3:0] lv;

        assign d  = Q[4*i +: 4];
        assign lv = load_val[4*i +: 4];

        assign up_val_c[4*i +: 4]  = !carry[i]  ? d : ((d == 4'd9) ? 4'd0 : d + 4'd1);
        assign dn_val_c[4*i +: 4]  = !borrow[i] ? d : ((d == 4'd0) ? 4'd9 : d - 4'd1);
        assign carry[i+1]          = carry[i]  && (d == 4'd9);
        assign borrow[i+1]         = borrow[i] && (d == 4'd0);
        assign sat_val_c[4*i +: 4] = (lv > 4'd9) ? 4'd9 : lv;
      end

      assign up_wrap_c = carry[DIGITS];
      assign dn_wrap_c = borrow[DIGITS];
    end else begin : g_bin
      assign {up_wrap_c, up_val_c} = {1'b0, Q} + WC'(1);
      assign dn_val_c              = Q - W'(1);
      assign dn_wrap_c             = (Q == '0);
      assign sat_val_c             = load_val;
    end
  endgenerate

  // Next count: clear, then load, then tick-gated step, else hold.
  always_comb begin
    q_d    = Q;
    rc_d   = 1'b0;
    step_c = tick && en && !clr && !load;
    if (clr) begin
      q_d = '0;
    end else if (load) begin
      q_d = sat_val_c;
    end else if (step_c) begin
      q_d  = up ? up_val_c  : dn_val_c;
      rc_d = up ? up_wrap_c : dn_wrap_c;
    end
  end

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      pre_q <= '0;
      tick  <= 1'b0;
      Q     <= '0;
      Rc    <= 1'b0;
    end else begin
      pre_q <= pre_d;
      tick  <= pre_last_c;
      Q     <= q_d;
      Rc    <= rc_d;
    end
  end

endmodule
